// File: rtl/decoder_pkg.sv
// Shared mode codes, FSM state encoding and sizing helper for the sequenced decoder.
package decoder_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_DIRECT = 2'b01,
        S_SCAN   = 2'b10,
        S_SWEEP  = 2'b11
    } state_t;

    // A divider of 1 still needs a one-bit counter so the compare logic stays uniform.
    function automatic int tick_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/decoder_core.sv
// Combinational N-to-2^N one-hot decoder; all outputs low when en is low.
module decoder_core #(
    parameter int N = 3
) (
    input  logic            en,
    input  logic [N-1:0]    a,
    output logic [2**N-1:0] y
);

    generate
        for (genvar gi = 0; gi < 2**N; gi++) begin : g_line
            assign y[gi] = en && (a == N'(gi));
        end
    endgenerate

endmodule

// File: rtl/decoder_seq.sv
// Sequenced one-hot select driver: direct decode, free-running scan and one-shot sweep,
// with registered outputs and optional active-low polarity on Y.
module decoder_seq
    import decoder_pkg::*;
#(
    parameter int N          = 3,
    parameter int DIV        = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            E,
    input  logic [1:0]      mode,
    input  logic [N-1:0]    A,
    input  logic            start,
    output logic [2**N-1:0] Y,
    output logic [N-1:0]    idx,
    output logic            valid,
    output logic            busy,
    output logic            done
);

    localparam int             W         = 2**N;
    localparam int             TW        = tick_width(DIV);
    localparam logic [TW-1:0]  TICK_LAST = TW'(DIV - 1);
    localparam logic [N-1:0]   IDX_LAST  = {N{1'b1}};
    localparam logic [W-1:0]   Y_IDLE    = {W{ACTIVE_LOW}};

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d, tick_step;
    logic [N-1:0]    idx_q, idx_d, idx_step;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    y_q, y_d, dec;
    logic            tick_wrap;

    assign tick_wrap = (tick_q == TICK_LAST);
    assign tick_step = tick_wrap ? '0 : tick_q + TW'(1);
    assign idx_step  = tick_wrap ? idx_q + N'(1) : idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!E) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    case (mode)
                        MODE_DIRECT: state_d = S_DIRECT;
                        MODE_SCAN:   state_d = S_SCAN;
                        MODE_SWEEP:  state_d = start ? S_SWEEP : S_IDLE;
                        default:     state_d = S_IDLE;
                    endcase
                end
                S_DIRECT: if (mode != MODE_DIRECT) state_d = S_IDLE;
                S_SCAN:   if (mode != MODE_SCAN)   state_d = S_IDLE;
                S_SWEEP: begin
                    if (mode != MODE_SWEEP || (idx_q == IDX_LAST && tick_wrap)) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Every path that does not stay in an active state falls back to the all-off defaults.
    always_comb begin
        tick_d  = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (E) begin
            case (state_q)
                S_IDLE: begin
                    if (state_d == S_SCAN) begin
                        valid_d = 1'b1;
                    end else if (state_d == S_SWEEP) begin
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
                S_DIRECT: begin
                    if (state_d == S_DIRECT) begin
                        idx_d   = A;
                        valid_d = 1'b1;
                    end
                end
                S_SCAN: begin
                    if (state_d == S_SCAN) begin
                        tick_d  = tick_step;
                        idx_d   = idx_step;
                        valid_d = 1'b1;
                    end
                end
                S_SWEEP: begin
                    if (state_d == S_SWEEP) begin
                        tick_d  = tick_step;
                        idx_d   = idx_step;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else if (mode == MODE_SWEEP) begin
                        done_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    decoder_core #(.N(N)) u_core (
        .en (valid_d),
        .a  (idx_d),
        .y  (dec)
    );

    assign y_d = ACTIVE_LOW ? ~dec : dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= Y_IDLE;
        end else begin
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            y_q     <= y_d;
        end
    end

    assign Y     = y_q;
    assign idx   = idx_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Bench for decoder_seq: two instances (DIV=4 active-high, DIV=1 active-low) against a cycle-count model.
module tb_decoder_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       e = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] a = 3'd0;

    logic [7:0] y0, y1;
    logic [2:0] idx0, idx1;
    logic       valid0, valid1, busy0, busy1, done0, done1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decoder_seq #(.N(3), .DIV(4), .ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .E(e), .mode(mode), .A(a), .start(start),
        .Y(y0), .idx(idx0), .valid(valid0), .busy(busy0), .done(done0)
    );

    decoder_seq #(.N(3), .DIV(1), .ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .E(e), .mode(mode), .A(a), .start(start),
        .Y(y1), .idx(idx1), .valid(valid1), .busy(busy1), .done(done1)
    );

    // Model phase: 0 off, 1 direct, 2 scan, 3 sweep; cnt = cycles since entering the phase.
    typedef struct {
        int       ph;
        int       cnt;
        logic [2:0] idx;
        logic     valid;
        logic     busy;
        logic     done;
    } mst_t;

    mst_t ms [2];

    function automatic mst_t step(input mst_t s, input int div, input logic en,
                                  input logic [1:0] m, input logic st, input logic [2:0] av);
        mst_t n;
        n.ph = 0; n.cnt = 0; n.idx = 3'd0; n.valid = 1'b0; n.busy = 1'b0; n.done = 1'b0;
        if (!en) return n;
        case (s.ph)
            0: begin
                if (m == 2'd0) n.ph = 1;
                else if (m == 2'd1) begin n.ph = 2; n.valid = 1'b1; end
                else if (m == 2'd2 && st) begin n.ph = 3; n.valid = 1'b1; n.busy = 1'b1; end
            end
            1: if (m == 2'd0) begin n.ph = 1; n.idx = av; n.valid = 1'b1; end
            2: if (m == 2'd1) begin
                n.ph = 2; n.cnt = s.cnt + 1; n.idx = 3'((n.cnt / div) % 8); n.valid = 1'b1;
            end
            3: if (m == 2'd2) begin
                if (s.cnt + 1 == 8 * div) begin
                    n.done = 1'b1;
                end else begin
                    n.ph = 3; n.cnt = s.cnt + 1; n.idx = 3'(n.cnt / div);
                    n.valid = 1'b1; n.busy = 1'b1;
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms[0] <= '{0, 0, 3'd0, 1'b0, 1'b0, 1'b0};
            ms[1] <= '{0, 0, 3'd0, 1'b0, 1'b0, 1'b0};
        end else begin
            ms[0] <= step(ms[0], 4, e, mode, start, a);
            ms[1] <= step(ms[1], 1, e, mode, start, a);
        end
    end

    logic [13:0] act0, act1, exp0, exp1;
    logic [7:0]  oh0, oh1;

    always_comb begin
        oh0  = ms[0].valid ? (8'h01 << ms[0].idx) : 8'h00;
        oh1  = ms[1].valid ? (8'h01 << ms[1].idx) : 8'h00;
        exp0 = {oh0, ms[0].idx, ms[0].valid, ms[0].busy, ms[0].done};
        exp1 = {~oh1, ms[1].idx, ms[1].valid, ms[1].busy, ms[1].done};
        act0 = {y0, idx0, valid0, busy0, done0};
        act1 = {y1, idx1, valid1, busy1, done1};
    end

    task automatic test_reset();
        rst_n = 1'b0; e = 1'b0; mode = 2'd0; a = 3'd0; start = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (y0 !== 8'h00 || valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            fails++; $display("FAIL reset_dut0 got %h required %h", act0, 14'h0);
        end
        tests++;
        if (y1 !== 8'hFF || valid1 !== 1'b0) begin
            fails++; $display("FAIL reset_dut1 got y=%h required y=ff", y1);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (act0 !== exp0) begin fails++; $display("FAIL reset_e0_dut0 got %h required %h", act0, exp0); end
            tests++;
            if (act1 !== exp1) begin fails++; $display("FAIL reset_e0_dut1 got %h required %h", act1, exp1); end
        end
        $display("[TB] test_reset complete");
    endtask

    task automatic test_direct();
        logic [7:0] one;
        one = 8'h01;
        e = 1'b0; start = 1'b0;
        @(negedge clk);
        e = 1'b1; mode = 2'd0;
        @(negedge clk);
        tests++;
        if (act0 !== exp0 || valid0 !== 1'b0) begin
            fails++; $display("FAIL direct_entry got %h required %h", act0, exp0);
        end
        for (int i = 0; i < 24; i++) begin
            a = (i < 8) ? 3'(i) : 3'($urandom_range(7));
            @(negedge clk);
            tests++;
            if (y0 !== (one << a) || idx0 !== a || valid0 !== 1'b1) begin
                fails++; $display("FAIL direct_decode a=%0d got y=%h idx=%0d required y=%h", a, y0, idx0, one << a);
            end
            tests++;
            if (act0 !== exp0) begin fails++; $display("FAIL direct_dut0 got %h required %h", act0, exp0); end
            tests++;
            if (act1 !== exp1) begin fails++; $display("FAIL direct_dut1 got %h required %h", act1, exp1); end
        end
        $display("[TB] test_direct complete");
    endtask

    task automatic test_scan();
        logic [7:0] one;
        one = 8'h01;
        e = 1'b0;
        @(negedge clk);
        e = 1'b1; mode = 2'd1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            tests++;
            if (idx0 !== 3'((j / 4) % 8) || y0 !== (one << idx0)) begin
                fails++; $display("FAIL scan_div4 cycle=%0d got idx=%0d y=%h required idx=%0d", j, idx0, y0, (j / 4) % 8);
            end
            tests++;
            if (y1 !== ~(one << (j % 8))) begin
                fails++; $display("FAIL scan_div1_lowpol cycle=%0d got %h required %h", j, y1, ~(one << (j % 8)));
            end
            tests++;
            if (act0 !== exp0) begin fails++; $display("FAIL scan_dut0 got %h required %h", act0, exp0); end
            tests++;
            if (act1 !== exp1) begin fails++; $display("FAIL scan_dut1 got %h required %h", act1, exp1); end
        end
        $display("[TB] test_scan complete");
    endtask

    task automatic test_sweep();
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0; done_cnt = 0;
        e = 1'b0; mode = 2'd2; start = 1'b0;
        @(negedge clk);
        e = 1'b1; start = 1'b1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            start = (j == 10);
            if (busy0 === 1'b1) busy_cnt++;
            if (done0 === 1'b1) done_cnt++;
            tests++;
            if (act0 !== exp0) begin fails++; $display("FAIL sweep_dut0 cycle=%0d got %h required %h", j, act0, exp0); end
            tests++;
            if (act1 !== exp1) begin fails++; $display("FAIL sweep_dut1 cycle=%0d got %h required %h", j, act1, exp1); end
        end
        tests++;
        if (busy_cnt != 32) begin fails++; $display("FAIL sweep_busy_len got %0d required 32", busy_cnt); end
        tests++;
        if (done_cnt != 1) begin fails++; $display("FAIL sweep_done_pulses got %0d required 1", done_cnt); end
        $display("[TB] test_sweep complete");
    endtask

    // sc 0: drop E at idx 3; sc 1: switch mode to DIRECT at idx 3; sc 2: drop E on the final tick.
    task automatic test_abort();
        for (int sc = 0; sc < 3; sc++) begin
            bit found;
            int sevens;
            found = 1'b0; sevens = 0;
            e = 1'b0; mode = 2'd2; start = 1'b0;
            @(negedge clk);
            e = 1'b1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int j = 0; j < 40; j++) begin
                @(negedge clk);
                tests++;
                if (act0 !== exp0) begin fails++; $display("FAIL abort_run_dut0 got %h required %h", act0, exp0); end
                if (idx0 === 3'd7 && busy0 === 1'b1) sevens++;
                if ((sc < 2 && idx0 === 3'd3) || (sc == 2 && sevens == 4)) begin
                    found = 1'b1;
                    break;
                end
            end
            tests++;
            if (!found) begin fails++; $display("FAIL abort_wait scenario=%0d got timeout required trigger", sc); end
            if (sc == 1) mode = 2'd0;
            else e = 1'b0;
            @(negedge clk);
            tests++;
            if (y0 !== 8'h00 || busy0 !== 1'b0 || done0 !== 1'b0 || valid0 !== 1'b0) begin
                fails++; $display("FAIL abort_resp scenario=%0d got y=%h busy=%b done=%b required y=00 busy=0 done=0", sc, y0, busy0, done0);
            end
            tests++;
            if (act0 !== exp0) begin fails++; $display("FAIL abort_dut0 got %h required %h", act0, exp0); end
            tests++;
            if (act1 !== exp1) begin fails++; $display("FAIL abort_dut1 got %h required %h", act1, exp1); end
            @(negedge clk);
            tests++;
            if (done0 !== 1'b0) begin fails++; $display("FAIL abort_late_done scenario=%0d got %b required 0", sc, done0); end
        end
        $display("[TB] test_abort complete");
    endtask

    task automatic test_async_reset();
        e = 1'b0;
        @(negedge clk);
        e = 1'b1; mode = 2'd1;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (y0 !== 8'h00 || valid0 !== 1'b0 || idx0 !== 3'd0) begin
            fails++; $display("FAIL async_reset_dut0 got y=%h valid=%b required y=00 valid=0", y0, valid0);
        end
        tests++;
        if (y1 !== 8'hFF) begin fails++; $display("FAIL async_reset_dut1 got %h required ff", y1); end
        @(negedge clk);
        rst_n = 1'b1; e = 1'b0;
        @(negedge clk);
        tests++;
        if (act0 !== exp0) begin fails++; $display("FAIL async_release_dut0 got %h required %h", act0, exp0); end
        $display("[TB] test_async_reset complete");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            e = ($urandom_range(15) != 0);
            if ($urandom_range(7) == 0) mode = 2'($urandom_range(3));
            start = ($urandom_range(3) == 0);
            a = 3'($urandom_range(7));
            @(negedge clk);
            tests++;
            if (act0 !== exp0) begin fails++; $display("FAIL random_dut0 i=%0d got %h required %h", i, act0, exp0); end
            tests++;
            if (act1 !== exp1) begin fails++; $display("FAIL random_dut1 i=%0d got %h required %h", i, act1, exp1); end
        end
        $display("[TB] test_random complete");
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan();
        test_sweep();
        test_abort();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised N-to-2^N one-hot decoder with registered outputs; successor to the fixed 3-to-8 decoder.
- Adds three operating modes:
  - DIRECT: registered decode of input A.
  - SCAN: free-running index sweep, for display and row multiplexing.
  - SWEEP: one-shot pass through all indices, started by a pulse, with a completion pulse.
- Sits between control logic and select lines of muxed peripherals (LED digits, memory banks).

Parameters:
- N, 3: select width; output width is 2^N.
- DIV, 4: clock cycles each index is held in SCAN/SWEEP; must be >=1.
- ACTIVE_LOW, 0: 1 inverts Y, so the selected line is 0 and idle lines are 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- E  in  1  global enable.
- mode  in  2  00 DIRECT, 01 SCAN, 10 SWEEP, 11 reserved.
- A  in  N  select index, used in DIRECT only.
- start  in  1  SWEEP start, sampled high for one cycle.
- Y  out  2^N  one-hot decoded output, registered.
- idx  out  N  index currently driven on Y.
- valid  out  1  Y carries a selected line.
- busy  out  1  SWEEP in progress.
- done  out  1  one-cycle pulse at SWEEP completion.

Behaviour:
- Reset (rst_n=0, async): state IDLE; tick counter 0; idx=0; valid=0; busy=0; done=0; Y inactive (all 0, or all 1 if ACTIVE_LOW).
- Inactive Y means all lines deasserted. Active Y means bit idx asserted, all others deasserted.
- States: IDLE, DIRECT, SCAN, SWEEP. All decisions are made on the rising clk edge.
- E=0 sampled, from any state:
  - Next state IDLE; Y inactive; valid=0; busy=0; tick counter=0; idx=0.
  - done is not pulsed.
  - E=0 has priority over every other event.
- IDLE with E=1:
  - mode 00 -> DIRECT; mode 01 -> SCAN.
  - mode 10 with start=1 -> SWEEP; mode 10 with start=0 -> stay in IDLE.
  - mode 11 -> stay in IDLE, Y inactive.
- DIRECT:
  - Each cycle, Y <= decode(A) and idx <= A; valid=1.
  - Latency 1 cycle from A to Y.
  - The first valid Y appears on the edge after entry into DIRECT.
- SCAN:
  - On entry, idx=0 and Y=decode(0) on the entry edge; valid=1.
  - The tick counter counts 0..DIV-1. When it equals DIV-1, it clears and idx increments.
  - idx wraps from 2^N-1 to 0. Every index is held exactly DIV cycles.
  - DIV=1: idx advances every cycle.
- SWEEP:
  - Entry edge: busy=1; idx=0; Y=decode(0); valid=1.
  - idx steps as in SCAN.
  - When idx=2^N-1 and the tick counter equals DIV-1: next state IDLE; Y inactive; valid=0; busy=0; done=1 for exactly one cycle; idx=0.
  - Total busy duration is 2^N*DIV cycles.
  - start while busy is ignored.
- Mode change while E=1:
  - In DIRECT or SCAN, any change to mode: next state IDLE, Y inactive, valid=0. Re-dispatch happens from IDLE on the following cycle.
  - In SWEEP, any change of mode away from 10 aborts: Y inactive; busy=0; no done pulse.
- Simultaneous events:
  - E falling on the final SWEEP tick gives no done pulse.
  - start with mode 10 in IDLE on the same cycle E rises is accepted.
- Widths:
  - Tick counter is max(1, $clog2(DIV)) bits.
  - idx increment is modulo 2^N, with no carry out.
- ACTIVE_LOW applies only at the output register. The internal logic is active-high.

Decomposition:
- Shared header/package decoder_pkg holds:
  - mode codes MODE_DIRECT=2'b00, MODE_SCAN=2'b01, MODE_SWEEP=2'b10, MODE_RSVD=2'b11;
  - state encodings S_IDLE, S_DIRECT, S_SCAN, S_SWEEP.
- One sub-module, decoder_core: purely combinational N-to-2^N one-hot decode with enable, parametrised by N.
  - decoder_seq owns the FSM, tick counter, idx register, output register and polarity inversion.

Test Plan:
- Reset/enable: N=3; rst_n=0, then release with E=0 -> Y=8'h00, valid=0. Assert rst_n=0 mid-SCAN -> Y=8'h00 immediately, without waiting for clk.
- DIRECT: E=1, mode=00, A=0..7, one value per cycle -> Y=8'h01,02,04,...,80, each one cycle after A; idx tracks A; valid=1.
- SCAN: N=3, DIV=4, E=1, mode=01 -> idx holds 0 for 4 cycles, then 1, ..., 7, then wraps to 0 at cycle 32; Y one-hot matches idx.
- SWEEP: DIV=4, mode=10, start pulse -> busy=1 for 32 cycles; Y steps 01..80; then Y=00, busy=0, done=1 for one cycle. A second start during busy has no effect.
- Abort: mid-SWEEP at idx=3, drop E -> next edge Y=00, busy=0, no done pulse. Repeat, switching mode to 00 instead of dropping E -> same abort response.
- Polarity/DIV edge: ACTIVE_LOW=1, DIV=1, mode=01 -> Y cycles FE,FD,FB,...,7F, advancing every clock; after reset, Y=FF.
